// File: rtl/round_judge_pkg.sv
// Shared game definitions: FSM encoding, result bundle and block defaults.
package round_judge_pkg;

    localparam int SETTLE_CYCLES_DEF = 4;
    localparam int WIN_TARGET_DEF    = 9;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        SETTLE = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic p1_win;
        logic p2_win;
        logic draw;
    } result_t;

endpackage

// File: rtl/round_judge_bcd_sat_counter.sv
// Single-digit BCD up-counter that sticks at 9 instead of wrapping.
module bcd_sat_counter
    import round_judge_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q
);

    // Clear wins over increment; increments at 9 are dropped.
    always_ff @(posedge clk) begin
        if (clr)
            q <= 4'd0;
        else if (inc && (q != BCD_MAX))
            q <= q + 4'd1;
    end

endmodule

// File: rtl/round_judge.sv
// Two-player round referee: waits for a crash, widens it into a coincidence
// window, reports the round result until acknowledged and keeps the score.
module round_judge
    import round_judge_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int WIN_TARGET    = WIN_TARGET_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       crash1,
    input  logic       crash2,
    input  logic       ack,
    output logic       p1_win,
    output logic       p2_win,
    output logic       draw,
    output logic       round_active,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       match_over
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] TARGET      = 4'(WIN_TARGET);

    state_t     state, state_n;
    logic [3:0] settle_cnt, settle_cnt_n;
    logic       c1, c1_n, c2, c2_n;
    result_t    res, res_n;
    logic       inc1, inc2;

    // State, window counter, sticky crash bits and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            c1         <= 1'b0;
            c2         <= 1'b0;
            res        <= '0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_cnt_n;
            c1         <= c1_n;
            c2         <= c2_n;
            res        <= res_n;
        end
    end

    // Next-state logic. The coincidence window is the first-crash edge plus
    // the following SETTLE_CYCLES-1 edges; the exit edge only decodes the
    // sticky bits, so a crash landing exactly on it is too late to count.
    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        c1_n         = c1;
        c2_n         = c2;
        res_n        = res;
        inc1         = 1'b0;
        inc2         = 1'b0;
        case (state)
            IDLE: begin
                if (start && !match_over) begin
                    state_n      = PLAY;
                    settle_cnt_n = 4'd0;
                    c1_n         = 1'b0;
                    c2_n         = 1'b0;
                end
            end
            PLAY: begin
                if (crash1 || crash2) begin
                    state_n      = SETTLE;
                    settle_cnt_n = 4'd0;
                    c1_n         = crash1;
                    c2_n         = crash2;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_n      = REPORT;
                    settle_cnt_n = 4'd0;
                    res_n.draw   = c1 && c2;
                    res_n.p1_win = c2 && !c1;
                    res_n.p2_win = c1 && !c2;
                    inc1         = c2 && !c1;
                    inc2         = c1 && !c2;
                end else begin
                    settle_cnt_n = settle_cnt + 4'd1;
                    c1_n         = c1 || crash1;
                    c2_n         = c2 || crash2;
                end
            end
            REPORT: begin
                if (ack) begin
                    res_n   = '0;
                    c1_n    = 1'b0;
                    c2_n    = 1'b0;
                    state_n = match_over ? DONE : IDLE;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    bcd_sat_counter u_score1 (
        .clk (clk),
        .clr (reset),
        .inc (inc1),
        .q   (score1)
    );

    bcd_sat_counter u_score2 (
        .clk (clk),
        .clr (reset),
        .inc (inc2),
        .q   (score2)
    );

    // Scores only move up and clear on reset, so this holds once reached.
    assign match_over   = (score1 >= TARGET) || (score2 >= TARGET);
    assign round_active = (state == PLAY) || (state == SETTLE);
    assign p1_win       = res.p1_win;
    assign p2_win       = res.p2_win;
    assign draw         = res.draw;

endmodule
